irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Parametrised interrupt controller for the single-cycle MIPS core, replacing the
//  fixed 3-source inline logic. Latches NUM_IRQ edge-triggered sources, applies a
//  software mask and global enable, and selects the highest-priority request
//  (index 0 highest). Tells the PC mux to take the request, supplies the vector,
//  and saves the return PC on a DEPTH-entry EPC stack popped by eret.
// PARAMETERS
//  NUM_IRQ    3            number of interrupt sources (1..32)
//  DEPTH      4            EPC stack depth / max nesting level (>=1)
//  AW         32           PC / vector width
//  VEC_BASE   32'h0000_0000 vector of channel 0
//  VEC_STRIDE 32'h0000_0010 vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE
// PORTS
//  clk         in   1         system clock; all state updates on posedge
//  rst_n       in   1         asynchronous active-low reset
//  irq_in      in   NUM_IRQ   raw sources, rising edge requests, synchronous to clk
//  pc_next     in   AW        PC the core would load this cycle (return address)
//  eret        in   1         return-from-interrupt strobe, one cycle
//  mask_we     in   1         write mask register
//  mask_wdata  in   NUM_IRQ   new mask, 1 = channel blocked
//  gie_we      in   1         write global enable
//  gie_wdata   in   1         new global enable
//  irq_take    out  1         combinational: core loads irq_vector instead of pc_next
//  irq_vector  out  AW        combinational vector of selected channel
//  irq_id      out  $clog2(NUM_IRQ)>0?..:1  selected channel index
//  epc         out  AW        top of EPC stack (eret target); 0 when stack empty
//  pending     out  NUM_IRQ   latched pending bits
//  in_service  out  NUM_IRQ   channels currently being serviced
//  mask        out  NUM_IRQ   current mask
//  gie         out  1         current global enable
//  level       out  $clog2(DEPTH+1)  current nesting depth
// BEHAVIOUR
//  Reset: pending, in_service, mask, level, EPC stack, irq_in history = 0; gie = 0.
//  Edge detect: irq_q <= irq_in each cycle; edge[i] = irq_in[i] & ~irq_q[i].
//   edge sets pending[i] at next posedge (one-cycle latency to visibility).
//  Eligible: req = pending & ~mask; gie=1; level < DEPTH; selected channel i =
//   lowest set index of req; i must be lower than lowest set index of in_service
//   (strict preemption; same or lower priority waits).
//  irq_take = eligible & ~eret. irq_vector/irq_id valid only while irq_take=1, else 0.
//  On posedge with irq_take: push pc_next, level+1, pending[i]<=0 (unless new
//   edge[i] same cycle: pending stays 1), in_service[i]<=1, gie unchanged.
//  On posedge with eret and level>0: pop, level-1, clear lowest-index set bit of
//   in_service. eret with level==0: ignored, no state change.
//  eret and eligible request same cycle: eret wins, irq_take=0, request retried
//   next cycle (tail-chain; epc then holds the new return addr).
//  mask_we/gie_we take effect next cycle; same-cycle take uses old values.
//  mask does not clear pending; unmasking later takes the held request.
//  level==DEPTH: no take; pending keeps accumulating, nothing is lost but repeat
//   edges on an already-pending channel merge into one request.
//  Reset asserted mid-service: all state cleared immediately, irq_take drops async.
// CONFIGURATION
//  IRQ_NEST_EN defined: nesting/preemption as above, up to DEPTH levels.
//  IRQ_NEST_EN undefined: effective depth 1; take only when level==0; single EPC
//   register; DEPTH ignored, level is 0/1.
// TESTING
//  1 reset, gie=1, mask=0, pulse irq_in[1], pc_next=0x100 -> irq_take 1 cycle later,
//    irq_vector=0x10, irq_id=1; after edge epc=0x100, level=1, pending[1]=0.
//  2 irq_in[2] and [0] edge same cycle -> take ch0 (vector 0x0); ch2 stays pending;
//    eret -> level 0, next cycle ch2 taken (vector 0x20), epc = new pc_next.
//  3 NEST_EN: in ch2 service, pulse ch0 -> preempt, level=2, epc=inner return;
//    pulse ch1 while ch0 active -> no take until eret; without NEST_EN ch0 waits.
//  4 mask[1]=1, pulse ch1 -> pending[1]=1, no take; clear mask -> take next cycle;
//    gie=0 blocks all takes, pending retained.
//  5 fill DEPTH=4 levels then pulse ch0 -> no take; eret at level 0 -> no change;
//    assert rst_n low mid-service -> all outputs 0 immediately.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller
//   Parameterised interrupt controller for the single-cycle MIPS core.
//   It latches edge-triggered sources and applies a software mask and a global
//   enable. It then picks the lowest-index eligible request and tells the PC
//   mux to load its vector. The return PC is saved on an EPC stack, and eret
//   pops that stack.
//
//   Build option: define IRQ_NEST_EN to allow strict-priority preemption up to
//   DEPTH levels. Without it the controller allows a single service level and
//   uses one EPC register.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   irq_in           raw interrupt sources; a rising edge requests service
//   pc_next          return address pushed when a request is taken
//   eret             return-from-interrupt strobe
//   mask_we/_wdata   mask register write (1 = channel blocked)
//   gie_we/_wdata    global interrupt enable write
//   irq_take         combinational: load irq_vector instead of pc_next
//   irq_vector       vector of the selected channel (0 unless irq_take)
//   irq_id           selected channel index (0 unless irq_take)
//   epc              top of the EPC stack, 0 when the stack is empty
//   pending          latched pending requests
//   in_service       channels currently being serviced
//   mask, gie        current mask and global enable
//   level            current nesting depth
module irq_controller #(
  parameter int             NUM_IRQ    = 3,
  parameter int             DEPTH      = 4,
  parameter int             AW         = 32,
  parameter logic [AW-1:0]  VEC_BASE   = '0,
  parameter logic [AW-1:0]  VEC_STRIDE = AW'(32'h10),
  localparam int            IW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int            LW         = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [AW-1:0]      pc_next,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               gie_we,
  input  logic               gie_wdata,
  output logic               irq_take,
  output logic [AW-1:0]      irq_vector,
  output logic [IW-1:0]      irq_id,
  output logic [AW-1:0]      epc,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] mask,
  output logic               gie,
  output logic [LW-1:0]      level
);

`ifdef IRQ_NEST_EN
  localparam int EDEPTH = DEPTH;
`else
  localparam int EDEPTH = 1;
`endif

  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, svc_q, svc_d, mask_q, mask_d;
  logic               gie_q, gie_d;
  logic [LW-1:0]      level_q, level_d;
  logic [AW-1:0]      stk_q [EDEPTH];

  logic [NUM_IRQ-1:0] edge_w, req, sel_oh;
  logic [IW-1:0]      sel, svc_top;
  logic               sel_any, svc_any, eligible, pop;

  assign edge_w = irq_in & ~irq_q;
  assign req    = pend_q & ~mask_q;

  // Lowest set index wins, both for requests and for the active service level.
  always_comb begin
    sel     = '0;
    sel_any = 1'b0;
    sel_oh  = '0;
    svc_top = '0;
    svc_any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel     = IW'(i);
        sel_any = 1'b1;
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
      end
      if (svc_q[i]) begin
        svc_top = IW'(i);
        svc_any = 1'b1;
      end
    end
  end

  // Preemption is strict: only a higher-priority channel than the one in service.
  assign eligible = sel_any && gie_q && (level_q < LW'(EDEPTH)) &&
                    (!svc_any || (sel < svc_top));
  // eret wins the cycle; the request simply retries once the pop has landed.
  assign irq_take   = eligible && !eret;
  assign pop        = eret && (level_q != '0);
  assign irq_id     = irq_take ? sel : '0;
  assign irq_vector = irq_take ? (VEC_BASE + AW'(sel) * VEC_STRIDE) : '0;

  always_comb begin
    epc = '0;
    for (int i = 0; i < EDEPTH; i++)
      if (level_q == LW'(i + 1)) epc = stk_q[i];
  end

  always_comb begin
    // A fresh edge on the channel being taken keeps it pending.
    pend_d  = (pend_q & ~(irq_take ? sel_oh : '0)) | edge_w;
    svc_d   = svc_q;
    level_d = level_q;
    mask_d  = mask_we ? mask_wdata : mask_q;
    gie_d   = gie_we ? gie_wdata : gie_q;
    if (irq_take) begin
      svc_d   = svc_q | sel_oh;
      level_d = level_q + LW'(1);
    end else if (pop) begin
      // The innermost level is always the highest-priority bit in service.
      svc_d   = svc_q & (svc_q - NUM_IRQ'(1));
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pend_q  <= '0;
      svc_q   <= '0;
      mask_q  <= '0;
      gie_q   <= 1'b0;
      level_q <= '0;
      for (int i = 0; i < EDEPTH; i++) stk_q[i] <= '0;
    end else begin
      irq_q   <= irq_in;
      pend_q  <= pend_d;
      svc_q   <= svc_d;
      mask_q  <= mask_d;
      gie_q   <= gie_d;
      level_q <= level_d;
      for (int i = 0; i < EDEPTH; i++)
        if (irq_take && (level_q == LW'(i))) stk_q[i] <= pc_next;
    end
  end

  assign pending    = pend_q;
  assign in_service = svc_q;
  assign mask       = mask_q;
  assign gie        = gie_q;
  assign level      = level_q;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed stimulus, a queue-based reference
// model compared every cycle, and hand-computed literal checkpoints.
module tb_irq_controller;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int AW = 32;
  localparam int IW = 3;
  localparam int LW = 3;
`ifdef IRQ_NEST_EN
  localparam int ED = D;
`else
  localparam int ED = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_in, mask_wdata;
  logic [AW-1:0] pc_next;
  logic          eret, mask_we, gie_we, gie_wdata;
  logic          irq_take, gie;
  logic [AW-1:0] irq_vector, epc;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending, in_service, mask;
  logic [LW-1:0] level;

  irq_controller #(.NUM_IRQ(N), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .pc_next(pc_next), .eret(eret),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .gie_we(gie_we),
    .gie_wdata(gie_wdata), .irq_take(irq_take), .irq_vector(irq_vector),
    .irq_id(irq_id), .epc(epc), .pending(pending), .in_service(in_service),
    .mask(mask), .gie(gie), .level(level)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a set of pending bits, plus stacks of the channels in
  // service and of their return addresses.
  logic [N-1:0]  m_pend, m_mask, m_prev;
  logic          m_gie;
  int            svc[$];
  logic [AW-1:0] epcs[$];

  function automatic int m_sel();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit m_take(input logic er);
    int s;
    s = m_sel();
    if (s < 0 || !m_gie || er) return 1'b0;
    if (svc.size() >= ED) return 1'b0;
    if (svc.size() > 0 && s >= svc[$]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 1'b0;
      svc.delete(); epcs.delete();
    end else begin
      bit t;
      int s;
      t = m_take(eret);
      s = m_sel();
      if (t) begin
        svc.push_back(s);
        epcs.push_back(pc_next);
        m_pend[s] = 1'b0;
      end else if (eret && svc.size() > 0) begin
        void'(svc.pop_back());
        void'(epcs.pop_back());
      end
      m_pend = m_pend | (irq_in & ~m_prev);
      m_prev = irq_in;
      if (mask_we) m_mask = mask_wdata;
      if (gie_we)  m_gie  = gie_wdata;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit t;
      int s;
      logic [N-1:0]  isv;
      logic [AW-1:0] xe;
      t = m_take(eret);
      s = m_sel();
      isv = '0;
      foreach (svc[k]) isv[svc[k]] = 1'b1;
      xe = (epcs.size() > 0) ? epcs[$] : '0;
      chk("take",       64'(irq_take),   64'(t));
      chk("vector",     64'(irq_vector), t ? 64'(s * 16) : 64'(0));
      chk("id",         64'(irq_id),     t ? 64'(s) : 64'(0));
      chk("epc",        64'(epc),        64'(xe));
      chk("pending",    64'(pending),    64'(m_pend));
      chk("in_service", 64'(in_service), 64'(isv));
      chk("mask",       64'(mask),       64'(m_mask));
      chk("gie",        64'(gie),        64'(m_gie));
      chk("level",      64'(level),      64'(svc.size()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    irq_in = '0; pc_next = '0; eret = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    gie_we = 1'b0; gie_wdata = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_take",  64'(irq_take), 64'(0));
    chk("rst_level", 64'(level),    64'(0));
    chk("rst_gie",   64'(gie),      64'(0));
    chk("rst_epc",   64'(epc),      64'(0));
    rst_n = 1'b1;
    gie_we = 1'b1; gie_wdata = 1'b1;
    step();
    gie_we = 1'b0;

    // Single request on channel 1.
    irq_in = 5'b00010; pc_next = 32'h100;
    step();
    irq_in = '0; #2;
    chk("t1_take", 64'(irq_take),   64'(1));
    chk("t1_vec",  64'(irq_vector), 64'(32'h10));
    chk("t1_id",   64'(irq_id),     64'(1));
    step(); #2;
    chk("t1_epc",   64'(epc),        64'(32'h100));
    chk("t1_level", 64'(level),      64'(1));
    chk("t1_pend1", 64'(pending[1]), 64'(0));
    eret = 1'b1;
    step();
    eret = 1'b0; #2;
    chk("t1_ret_level", 64'(level), 64'(0));

    // Simultaneous edges on channels 0 and 2.
    irq_in = 5'b00101; pc_next = 32'h200;
    step();
    irq_in = '0; #2;
    chk("t2_id0",  64'(irq_id),     64'(0));
    chk("t2_vec0", 64'(irq_vector), 64'(0));
    chk("t2_take", 64'(irq_take),   64'(1));
    step(); #2;
    chk("t2_epc",  64'(epc),     64'(32'h200));
    chk("t2_pend", 64'(pending), 64'(5'b00100));
    eret = 1'b1; pc_next = 32'h300;
    step();
    eret = 1'b0; pc_next = 32'h304; #2;
    chk("t2_level0", 64'(level),      64'(0));
    chk("t2_id2",    64'(irq_id),     64'(2));
    chk("t2_vec2",   64'(irq_vector), 64'(32'h20));
    step(); #2;
    chk("t2_epc2", 64'(epc), 64'(32'h304));

    // Preemption by channel 0 while channel 2 is in service.
    irq_in = 5'b00001; pc_next = 32'h400;
    step();
    irq_in = '0; pc_next = 32'h404; #2;
`ifdef IRQ_NEST_EN
    chk("t3_preempt", 64'(irq_take), 64'(1));
`else
    chk("t3_wait",    64'(irq_take), 64'(0));
`endif
    step(); #2;
`ifdef IRQ_NEST_EN
    chk("t3_level", 64'(level), 64'(2));
    chk("t3_epc",   64'(epc),   64'(32'h404));
`else
    chk("t3_level", 64'(level), 64'(1));
    chk("t3_epc",   64'(epc),   64'(32'h304));
`endif
    irq_in = 5'b00010; pc_next = 32'h500;
    step();
    irq_in = '0; #2;
    chk("t3_ch1_wait", 64'(irq_take),   64'(0));
    chk("t3_ch1_pend", 64'(pending[1]), 64'(1));
    eret = 1'b1;
    step(); #2;
    chk("t3_eret_wins", 64'(irq_take), 64'(0));
    step();
    eret = 1'b0; #2;
    chk("t3_level0", 64'(level),    64'(0));
    chk("t3_retry",  64'(irq_take), 64'(1));
`ifdef IRQ_NEST_EN
    chk("t3_retry_id", 64'(irq_id), 64'(1));
`else
    chk("t3_retry_id", 64'(irq_id), 64'(0));
`endif
    repeat (10) begin
      eret = (level != '0) && !irq_take;
      pc_next = pc_next + 32'h4;
      step();
    end
    eret = 1'b0; #2;
    chk("drain_level", 64'(level),   64'(0));
    chk("drain_pend",  64'(pending), 64'(0));

    // Mask, then global enable.
    mask_we = 1'b1; mask_wdata = 5'b00010;
    step();
    mask_we = 1'b0; irq_in = 5'b00010;
    step();
    irq_in = '0; #2;
    chk("t4_masked_pend", 64'(pending[1]), 64'(1));
    chk("t4_masked_take", 64'(irq_take),   64'(0));
    mask_we = 1'b1; mask_wdata = '0; #2;
    chk("t4_old_mask", 64'(irq_take), 64'(0));
    step();
    mask_we = 1'b0; #2;
    chk("t4_unmask_take", 64'(irq_take), 64'(1));
    chk("t4_unmask_id",   64'(irq_id),   64'(1));
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    gie_we = 1'b1; gie_wdata = 1'b0;
    step();
    gie_we = 1'b0; irq_in = 5'b00100;
    step();
    irq_in = '0;
    repeat (2) step();
    #2;
    chk("t4_gie_block", 64'(irq_take),   64'(0));
    chk("t4_gie_pend",  64'(pending[2]), 64'(1));
    gie_we = 1'b1; gie_wdata = 1'b1;
    step();
    gie_we = 1'b0; #2;
    chk("t4_gie_take", 64'(irq_vector), 64'(32'h20));
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Fill every nesting level, then overflow and reset mid-service.
    pc_next = 32'h600;
    irq_in = 5'b10000; step();
    irq_in = 5'b01000; step();
    irq_in = 5'b00100; step();
    irq_in = 5'b00010; step();
    irq_in = '0;
    repeat (3) step();
    irq_in = 5'b00001;
    step();
    irq_in = '0;
    step(); #2;
    chk("t5_full_take", 64'(irq_take),   64'(0));
    chk("t5_full_pend", 64'(pending[0]), 64'(1));
    chk("t5_level",     64'(level),      64'(ED));
    rst_n = 1'b0; #1;
    chk("t5_rst_take",  64'(irq_take),   64'(0));
    chk("t5_rst_level", 64'(level),      64'(0));
    chk("t5_rst_epc",   64'(epc),        64'(0));
    chk("t5_rst_pend",  64'(pending),    64'(0));
    chk("t5_rst_svc",   64'(in_service), 64'(0));
    chk("t5_rst_gie",   64'(gie),        64'(0));
    step();
    rst_n = 1'b1;
    eret = 1'b1;
    step();
    eret = 1'b0; #2;
    chk("t5_eret_idle_level", 64'(level), 64'(0));
    chk("t5_eret_idle_epc",   64'(epc),   64'(0));
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
